// File: rtl/keccak_x_heep_pkg.sv
// Shared constants and types for the Keccak OBI slave: register map indices,
// STATUS bit positions, controller state encoding and the OBI bus structs.
package keccak_x_heep_pkg;

   localparam int KECCAK_NWORDS     = 50;
   localparam int KECCAK_DIN_IDX    = 0;
   localparam int KECCAK_DOUT_IDX   = 50;
   localparam int KECCAK_CTRL_IDX   = 100;
   localparam int KECCAK_STATUS_IDX = 101;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   // Crossbar slave port and base of the decoded address window.
   localparam int          KECCAK_IDX           = 5;
   localparam logic [31:0] KECCAK_START_ADDRESS = 32'h2003_0000;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY
   } keccak_state_e;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/keccak_ctrl_fsm.sv
// Keccak run controller: sequences IDLE -> START -> BUSY, produces the core
// start pulse and keeps the done flag and the level completion interrupt.
module keccak_ctrl_fsm
   import keccak_x_heep_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start_req,
   input  logic ready,
   input  logic status_rd,
   output logic start,
   output logic busy,
   output logic done,
   output logic intr,
   output logic capture
);

   keccak_state_e state;
   keccak_state_e state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start requests are only honoured from IDLE; ready only counts in BUSY.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start_req) begin
               state_next = START;
            end
         end
         START: begin
            start      = 1'b1;
            state_next = BUSY;
         end
         BUSY: begin
            if (ready) begin
               capture    = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // A completion sets the interrupt even when a STATUS read clears it in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         intr <= 1'b0;
      end else begin
         if (state == IDLE && start_req) begin
            done <= 1'b0;
         end else if (capture) begin
            done <= 1'b1;
         end
         if (capture) begin
            intr <= 1'b1;
         end else if (status_rd) begin
            intr <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/keccak_obi_slave.sv
// OBI slave front-end for the Keccak core: DIN/DOUT word buffers, CTRL/STATUS
// decode and registered responses. KECCAK_DOUT_BUFFER_EN adds a DOUT capture register.
module keccak_obi_slave
   import keccak_x_heep_pkg::*;
#(
   parameter int          NWORDS        = KECCAK_NWORDS,
   parameter logic [31:0] START_ADDRESS = KECCAK_START_ADDRESS
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  obi_req_t              slave_req_i,
   output obi_resp_t             slave_resp_o,
   output logic [NWORDS*32-1:0]  keccak_din_o,
   output logic                  keccak_start_o,
   input  logic [NWORDS*32-1:0]  keccak_dout_i,
   input  logic                  keccak_ready_i,
   output logic                  keccak_intr_o
);

   localparam int WW = $clog2(NWORDS);

   logic [31:0]         off;
   logic [17:0]         idx;
   logic                unused_off;
   logic                is_din;
   logic                is_dout;
   logic                is_ctrl;
   logic                is_status;
   logic [WW-1:0]       din_word;
   logic [WW-1:0]       dout_word;
   logic                din_we;
   logic                ctrl_start;
   logic                status_rd;
   logic                busy;
   logic                done;
   logic                capture;
   logic [NWORDS*32-1:0] din_q;
   logic [31:0]         dout_val;
   logic [31:0]         rd_word;
   logic                rvalid_q;
   logic [31:0]         rdata_q;

   assign off        = slave_req_i.addr - START_ADDRESS;
   assign idx        = off[19:2];
   assign unused_off = ^{off[31:20], off[1:0]};

   assign is_din    = idx < 18'(KECCAK_DIN_IDX + NWORDS);
   assign is_dout   = (idx >= 18'(KECCAK_DOUT_IDX)) && (idx < 18'(KECCAK_DOUT_IDX + NWORDS));
   assign is_ctrl   = idx == 18'(KECCAK_CTRL_IDX);
   assign is_status = idx == 18'(KECCAK_STATUS_IDX);
   assign din_word  = WW'(idx - 18'(KECCAK_DIN_IDX));
   assign dout_word = WW'(idx - 18'(KECCAK_DOUT_IDX));

   assign din_we     = slave_req_i.req && slave_req_i.we && is_din && !busy;
   assign ctrl_start = slave_req_i.req && slave_req_i.we && is_ctrl && slave_req_i.wdata[0];
   assign status_rd  = slave_req_i.req && !slave_req_i.we && is_status;

   keccak_ctrl_fsm u_ctrl_fsm (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .start_req (ctrl_start),
      .ready     (keccak_ready_i),
      .status_rd (status_rd),
      .start     (keccak_start_o),
      .busy      (busy),
      .done      (done),
      .intr      (keccak_intr_o),
      .capture   (capture)
   );

   // The input state is frozen while the core runs so it sees a stable din.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         din_q <= '0;
      end else if (din_we) begin
         for (int b = 0; b < 4; b++) begin
            if (slave_req_i.be[b]) begin
               din_q[int'(din_word)*32 + b*8 +: 8] <= slave_req_i.wdata[b*8 +: 8];
            end
         end
      end
   end

   assign keccak_din_o = din_q;

`ifdef KECCAK_DOUT_BUFFER_EN
   logic [NWORDS*32-1:0] dout_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dout_q <= '0;
      end else if (capture) begin
         dout_q <= keccak_dout_i;
      end
   end

   assign dout_val = dout_q[int'(dout_word)*32 +: 32];
`else
   logic unused_capture;

   assign unused_capture = capture;
   assign dout_val       = keccak_dout_i[int'(dout_word)*32 +: 32];
`endif

   always_comb begin
      rd_word = '0;
      if (is_din) begin
         rd_word = din_q[int'(din_word)*32 +: 32];
      end else if (is_dout) begin
         rd_word = dout_val;
      end else if (is_status) begin
         rd_word[STATUS_BUSY_BIT] = busy;
         rd_word[STATUS_DONE_BIT] = done;
      end
   end

   // Every granted request gets an rvalid one cycle later; writes return zero data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= slave_req_i.req;
         rdata_q  <= (slave_req_i.req && !slave_req_i.we) ? rd_word : 32'h0;
      end
   end

   assign slave_resp_o.gnt    = slave_req_i.req;
   assign slave_resp_o.rvalid = rvalid_q;
   assign slave_resp_o.rdata  = rdata_q;

endmodule

// File: tb/tb_keccak_obi_slave.sv
// Bench for keccak_obi_slave: a register-map vector table, directed run/reset
// sequences and a randomized phase against a word-level model of the slave.
module tb_keccak_obi_slave;
   import keccak_x_heep_pkg::*;

   localparam int NW = KECCAK_NWORDS;

   typedef struct {
      int          idx;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      string       name;
   } vec_t;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   obi_req_t           slave_req;
   obi_resp_t          slave_resp;
   logic [NW*32-1:0]   keccak_din;
   logic [NW*32-1:0]   keccak_dout;
   logic               keccak_start;
   logic               keccak_ready;
   logic               keccak_intr;

   int checks = 0;
   int errors = 0;
   int start_count = 0;
   int double_start = 0;
   logic prev_start = 1'b0;

   logic [31:0] m_din  [NW];
   logic [31:0] m_dout [NW];
   bit          m_busy, m_armed, m_done, m_intr;
   int          m_starts = 0;

   vec_t vecs[$];

   always #5 clk_i = ~clk_i;

   keccak_obi_slave dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .slave_req_i    (slave_req),
      .slave_resp_o   (slave_resp),
      .keccak_din_o   (keccak_din),
      .keccak_start_o (keccak_start),
      .keccak_dout_i  (keccak_dout),
      .keccak_ready_i (keccak_ready),
      .keccak_intr_o  (keccak_intr)
   );

   // Count start pulses and catch any pulse longer than one cycle.
   always @(negedge clk_i) begin
      if (keccak_start) begin
         start_count++;
         if (prev_start) double_start++;
      end
      prev_start = keccak_start;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] exp_dout(input int k);
`ifdef KECCAK_DOUT_BUFFER_EN
      return m_dout[k];
`else
      return keccak_dout[k*32 +: 32];
`endif
   endfunction

   function automatic logic [31:0] model_read(input int idx, input logic we);
      if (we) return 32'h0;
      if (idx < NW) return m_din[idx];
      if (idx >= 50 && idx < 100) return exp_dout(idx - 50);
      if (idx == 101) return {30'b0, m_done, m_busy};
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NW; k++) begin
         m_din[k]  = 32'h0;
         m_dout[k] = 32'h0;
      end
      m_busy  = 0;
      m_armed = 0;
      m_done  = 0;
      m_intr  = 0;
   endtask

   task automatic model_ready();
      m_done  = 1;
      m_intr  = 1;
      m_busy  = 0;
      m_armed = 0;
      for (int k = 0; k < NW; k++) m_dout[k] = keccak_dout[k*32 +: 32];
   endtask

   task automatic model_idle(input logic rdy);
      if (rdy && m_busy && m_armed) model_ready();
      else if (m_busy) m_armed = 1;
   endtask

   task automatic model_step(input int idx, input logic we, input logic [3:0] be,
                             input logic [31:0] wdata, input logic rdy);
      bit was_busy;
      was_busy = m_busy;
      if (we && idx < NW && !m_busy) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) m_din[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (!we && idx == 101) m_intr = 0;
      if (rdy && m_busy && m_armed) model_ready();
      if (we && idx == 100 && wdata[0] && !was_busy) begin
         m_busy   = 1;
         m_armed  = 0;
         m_done   = 0;
         m_starts++;
      end else if (was_busy && m_busy) begin
         m_armed = 1;
      end
   endtask

   // One OBI transaction: request held for one cycle, response sampled after the grant edge.
   task automatic apply_stimulus(input int idx, input logic we, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic rdy,
                                 output logic [31:0] rdata);
      @(negedge clk_i);
      slave_req    = '{req: 1'b1, addr: KECCAK_START_ADDRESS + 32'(idx * 4), we: we, be: be, wdata: wdata};
      keccak_ready = rdy;
      #1;
      check_output("gnt", {31'b0, slave_resp.gnt}, 32'h1);
      @(posedge clk_i);
      #1;
      slave_req.req = 1'b0;
      keccak_ready  = 1'b0;
      check_output("rvalid", {31'b0, slave_resp.rvalid}, 32'h1);
      rdata = slave_resp.rdata;
   endtask

   task automatic xfer(input int idx, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic rdy, output logic [31:0] rdata);
      apply_stimulus(idx, we, be, wdata, rdy, rdata);
      model_step(idx, we, be, wdata, rdy);
   endtask

   task automatic idle_cycle();
      @(posedge clk_i);
      #1;
      model_idle(1'b0);
   endtask

   task automatic ready_cycle();
      @(negedge clk_i);
      keccak_ready = 1'b1;
      @(posedge clk_i);
      #1;
      keccak_ready = 1'b0;
      model_idle(1'b1);
   endtask

   task automatic new_dout();
      for (int k = 0; k < NW; k++) keccak_dout[k*32 +: 32] = $urandom;
   endtask

   task automatic add_vec(input int idx, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp, input string name);
      vec_t v;
      v.idx = idx; v.we = we; v.be = be; v.wdata = wdata; v.exp_rdata = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp;
      int          s0;
      int          rvalid_count;
      int          op, idx;
      logic        we, rdy;
      logic [3:0]  be;
      logic [31:0] wdata;

      slave_req    = '0;
      keccak_ready = 1'b0;
      keccak_dout  = '0;
      model_reset();

      #12;
      check_output("reset_rvalid", {31'b0, slave_resp.rvalid}, 32'h0);
      check_output("reset_rdata", slave_resp.rdata, 32'h0);
      check_output("reset_start", {31'b0, keccak_start}, 32'h0);
      check_output("reset_intr", {31'b0, keccak_intr}, 32'h0);
      check_output("reset_din", {31'b0, |keccak_din}, 32'h0);
      #10 rst_ni = 1'b1;

      add_vec(101, 0, 4'hF, 32'h0,        32'h0,        "status_after_reset");
      add_vec(0,   1, 4'hF, 32'h11223344, 32'h0,        "din0_write_full");
      add_vec(0,   1, 4'h3, 32'hDEADBEEF, 32'h0,        "din0_write_be0011");
      add_vec(0,   0, 4'hF, 32'h0,        32'h1122BEEF, "din0_readback");
      add_vec(49,  1, 4'hC, 32'hA5A5A5A5, 32'h0,        "din49_write_be1100");
      add_vec(49,  0, 4'hF, 32'h0,        32'hA5A50000, "din49_readback");
      add_vec(120, 1, 4'hF, 32'hFFFFFFFF, 32'h0,        "unmapped_write");
      add_vec(150, 0, 4'hF, 32'h0,        32'h0,        "unmapped_read150");
      add_vec(120, 0, 4'hF, 32'h0,        32'h0,        "unmapped_read120");
      add_vec(51,  1, 4'hF, 32'h12345678, 32'h0,        "dout_write");
      add_vec(51,  0, 4'hF, 32'h0,        32'h0,        "dout_read_reset");
      add_vec(100, 1, 4'hF, 32'h0,        32'h0,        "ctrl_write_zero");
      add_vec(101, 0, 4'hF, 32'h0,        32'h0,        "status_still_idle");
      add_vec(102, 0, 4'hF, 32'h0,        32'h0,        "unmapped_read102");

      for (int i = 0; i < vecs.size(); i++) begin
         xfer(vecs[i].idx, vecs[i].we, vecs[i].be, vecs[i].wdata, 1'b0, rd);
         check_output(vecs[i].name, rd, vecs[i].exp_rdata);
      end
      check_output("din_o_word0", keccak_din[31:0], 32'h1122BEEF);
      check_output("din_o_word49", keccak_din[49*32 +: 32], 32'hA5A50000);
      check_output("no_start_yet", start_count, 0);

      $display("[TB] completion sequence");
      s0 = start_count;
      xfer(100, 1, 4'hF, 32'h1, 1'b0, rd);
      check_output("start_high", {31'b0, keccak_start}, 32'h1);
      idle_cycle();
      check_output("start_low", {31'b0, keccak_start}, 32'h0);
      xfer(101, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("status_busy", rd, 32'h1);
      new_dout();
      keccak_dout[63:32] = 32'hCAFEF00D;
      ready_cycle();
      check_output("intr_set", {31'b0, keccak_intr}, 32'h1);
      xfer(51, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("dout51", rd, 32'hCAFEF00D);
      check_output("intr_held", {31'b0, keccak_intr}, 32'h1);
      xfer(101, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("status_done", rd, 32'h2);
      check_output("intr_cleared", {31'b0, keccak_intr}, 32'h0);
      check_output("one_start", start_count - s0, 1);

      $display("[TB] busy sequence");
      s0 = start_count;
      xfer(3,   1, 4'hF, 32'h33333333, 1'b0, rd);
      xfer(100, 1, 4'hF, 32'h1,        1'b0, rd);
      xfer(3,   1, 4'hF, 32'h44444444, 1'b0, rd);
      xfer(100, 1, 4'hF, 32'h1,        1'b0, rd);
      xfer(3,   0, 4'hF, 32'h0,        1'b0, rd);
      check_output("din3_unchanged", rd, 32'h33333333);
      check_output("din_o_word3", keccak_din[3*32 +: 32], 32'h33333333);
      new_dout();
      xfer(101, 0, 4'hF, 32'h0, 1'b1, rd);
      check_output("status_with_ready", rd, 32'h1);
      check_output("intr_set_wins", {31'b0, keccak_intr}, 32'h1);
      xfer(101, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("status_done2", rd, 32'h2);
      check_output("intr_cleared2", {31'b0, keccak_intr}, 32'h0);
      check_output("single_start_busy", start_count - s0, 1);

      $display("[TB] back-to-back reads");
      rvalid_count = 0;
      @(negedge clk_i);
      for (int i = 0; i < 100; i++) begin
         slave_req = '{req: 1'b1, addr: KECCAK_START_ADDRESS + 32'((i % NW) * 4), we: 1'b0, be: 4'hF, wdata: 32'h0};
         exp = m_din[i % NW];
         @(posedge clk_i);
         #1;
         if (slave_resp.rvalid) rvalid_count++;
         check_output("b2b_rdata", slave_resp.rdata, exp);
         if (i != 99) @(negedge clk_i);
      end
      slave_req.req = 1'b0;
      check_output("b2b_rvalid_count", rvalid_count, 100);
      @(posedge clk_i);
      #1;
      check_output("rvalid_drop", {31'b0, slave_resp.rvalid}, 32'h0);

      $display("[TB] reset while busy");
      xfer(100, 1, 4'hF, 32'h1, 1'b0, rd);
      idle_cycle();
      idle_cycle();
      new_dout();
      ready_cycle();
      xfer(100, 1, 4'hF, 32'h1, 1'b0, rd);
      idle_cycle();
      idle_cycle();
      check_output("intr_pending_busy", {31'b0, keccak_intr}, 32'h1);
      #2 rst_ni = 1'b0;
      #1;
      model_reset();
      check_output("rst_intr", {31'b0, keccak_intr}, 32'h0);
      check_output("rst_din", {31'b0, |keccak_din}, 32'h0);
      check_output("rst_start", {31'b0, keccak_start}, 32'h0);
      check_output("rst_rvalid", {31'b0, slave_resp.rvalid}, 32'h0);
      #3 rst_ni = 1'b1;
      new_dout();
      ready_cycle();
      check_output("ready_ignored_intr", {31'b0, keccak_intr}, 32'h0);
      xfer(101, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("status_after_rst", rd, 32'h0);
      exp = model_read(50, 1'b0);
      xfer(50, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("dout_after_rst", rd, exp);
      xfer(0, 0, 4'hF, 32'h0, 1'b0, rd);
      check_output("din_after_rst", rd, 32'h0);

      $display("[TB] randomized phase");
      for (int i = 0; i < 400; i++) begin
         op    = $urandom_range(0, 6);
         be    = 4'($urandom);
         wdata = $urandom;
         we    = 1'b0;
         case (op)
            0: begin idx = $urandom_range(0, NW - 1); we = 1'b1; end
            1: idx = $urandom_range(0, NW - 1);
            2: idx = $urandom_range(50, 99);
            3: idx = 101;
            4: begin idx = 100; we = 1'b1; end
            5: begin idx = $urandom_range(102, 4000); we = 1'($urandom); end
            default: begin idx = $urandom_range(50, 99); we = 1'b1; end
         endcase
         rdy = m_busy && m_armed && ($urandom_range(0, 2) == 0);
         if (rdy) new_dout();
         exp = model_read(idx, we);
         xfer(idx, we, be, wdata, rdy, rd);
         check_output("rand_rdata", rd, exp);
         check_output("rand_intr", {31'b0, keccak_intr}, {31'b0, m_intr});
         if (idx < NW) check_output("rand_din_o", keccak_din[idx*32 +: 32], m_din[idx]);
      end
      idle_cycle();
      idle_cycle();
      check_output("total_starts", start_count, m_starts);
      check_output("start_width", double_start, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
